// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//
// Parametrised register file for the decode/writeback stages, with a hardware
// clear sequencer that zeroes the file one register per clock.
//
// Parameters:
//   DATA_WIDTH  bits per register
//   ADDR_WIDTH  register index width
//   NUM_REGS    implemented registers (2 .. 2**ADDR_WIDTH)
//   NUM_READ    number of combinational read ports (1 .. 4)
//   ZERO_REG    1 = register 0 always reads 0 and ignores writes
//
// Ports:
//   clock             rising-edge clock
//   ctrl_reset_n      asynchronous active-low reset (zeroes everything)
//   ctrl_writeEnable  write strobe
//   ctrl_writeReg     write index
//   data_writeReg     write data
//   ctrl_readReg      read indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   data_readReg      read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   ctrl_clear        starts a clear sweep when sampled high in IDLE
//   clear_busy        high while the sweep is running
//   write_dropped     one-cycle pulse after a write was discarded by a sweep
//   ctrl_debugSel     debug register select
//   output_register   contents of register ctrl_debugSel (never bypassed)
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, an accepted write is forwarded to any
//                      read port addressing the same register in that cycle.
// -----------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clock,
    input  logic                           ctrl_reset_n,
    input  logic                           ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]          data_writeReg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    input  logic                           ctrl_clear,
    output logic                           clear_busy,
    output logic                           write_dropped,
    input  logic [ADDR_WIDTH-1:0]          ctrl_debugSel,
    output logic [DATA_WIDTH-1:0]          output_register
);

    // Sweep counter is one bit wider than an index so that a full-size file
    // (NUM_REGS = 2**ADDR_WIDTH) can reach its last register without wrapping.
    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] LAST_IDX  = (ADDR_WIDTH+1)'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH:0] FIRST_IDX = (ADDR_WIDTH+1)'((ZERO_REG != 0) ? 1 : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } seqState_t;

    seqState_t             seqState;
    logic [ADDR_WIDTH:0]   clearIdx;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  writeValid;

    // A write to the hardwired zero register or past the implemented file is
    // simply ignored; it is neither stored nor reported as dropped.
    assign writeValid = ctrl_writeEnable
                     && ({1'b0, ctrl_writeReg} < REG_LIMIT)
                     && !((ZERO_REG != 0) && (ctrl_writeReg == '0));

    // Clear sequencer: state, sweep counter and its registered status outputs.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            seqState      <= IDLE;
            clearIdx      <= '0;
            clear_busy    <= 1'b0;
            write_dropped <= 1'b0;
        end else begin
            write_dropped <= 1'b0;
            case (seqState)
                IDLE: begin
                    if (ctrl_clear) begin
                        seqState   <= CLEAR;
                        clearIdx   <= FIRST_IDX;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    // ctrl_clear is deliberately ignored here: no restart.
                    write_dropped <= writeValid;
                    clearIdx      <= clearIdx + 1'b1;
                    if (clearIdx == LAST_IDX) begin
                        seqState   <= IDLE;
                        clear_busy <= 1'b0;
                    end
                end
                default: begin
                    seqState   <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // Storage: the sweep owns the write path while CLEAR; user writes only in
    // IDLE (including the cycle in which a clear is requested).
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (seqState == CLEAR) begin
                    if (clearIdx == (ADDR_WIDTH+1)'(r)) begin
                        regs[r] <= '0;
                    end
                end else if (writeValid && (ctrl_writeReg == ADDR_WIDTH'(r))) begin
                    regs[r] <= data_writeReg;
                end
            end
        end
    end

    // Combinational read ports and debug view. An index that matches no
    // implemented register (or the zero register) falls through to 0.
    always_comb begin
        data_readReg    = '0;
        output_register = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if ((ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
                    && !((ZERO_REG != 0) && (r == 0))) begin
                    data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = regs[r];
                end
            end
`ifdef REGFILE_BYPASS_EN
            // Write-through forwarding; writeValid already excludes the zero
            // register and out-of-range indices, and a sweep blocks it.
            if ((seqState == IDLE) && writeValid
                && (ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH] == ctrl_writeReg)) begin
                data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = data_writeReg;
            end
`endif
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            if ((ctrl_debugSel == ADDR_WIDTH'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
                output_register = regs[r];
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//
// Self-checking bench for regfile_param at default parameters. A behavioural
// model (array of register values plus sweep pointer) predicts every output;
// a compare process checks all outputs on each falling clock edge, and the
// directed sequence adds literal expectations.
// -----------------------------------------------------------------------------
module tb_regfile_param;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREG  = 32;
    localparam int NRD   = 2;
    localparam int ZREG  = 1;
    localparam int FIRST = (ZREG != 0) ? 1 : 0;

    logic               clock = 1'b0;
    logic               rst_n = 1'b1;
    logic               we = 1'b0;
    logic [AW-1:0]      wr = '0;
    logic [DW-1:0]      wd = '0;
    logic [NRD*AW-1:0]  rdIdx = '0;
    logic [NRD*DW-1:0]  rdData;
    logic               clr = 1'b0;
    logic               busy;
    logic               dropped;
    logic [AW-1:0]      dbgSel = '0;
    logic [DW-1:0]      dbgOut;

    int vectors     = 0;
    int miscompares = 0;
    bit checkOn     = 1'b0;

    regfile_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NREG), .NUM_READ(NRD), .ZERO_REG(ZREG)
    ) dut (
        .clock           (clock),
        .ctrl_reset_n    (rst_n),
        .ctrl_writeEnable(we),
        .ctrl_writeReg   (wr),
        .data_writeReg   (wd),
        .ctrl_readReg    (rdIdx),
        .data_readReg    (rdData),
        .ctrl_clear      (clr),
        .clear_busy      (busy),
        .write_dropped   (dropped),
        .ctrl_debugSel   (dbgSel),
        .output_register (dbgOut)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] model [NREG];
    bit            mBusy = 1'b0;
    int            mNext = 0;
    bit            mDrop = 1'b0;

    initial begin
        for (int i = 0; i < NREG; i++) model[i] = '0;
    end

    function automatic bit idxWritable(input int idx);
        return (idx < NREG) && !((ZREG != 0) && (idx == 0));
    endfunction

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) model[i] = '0;
            mBusy = 1'b0;
            mNext = 0;
            mDrop = 1'b0;
        end else if (!mBusy) begin
            mDrop = 1'b0;
            if (we && idxWritable(int'(wr))) model[int'(wr)] = wd;
            if (clr) begin
                mBusy = 1'b1;
                mNext = FIRST;
            end
        end else begin
            mDrop = we && idxWritable(int'(wr));
            model[mNext] = '0;
            mNext = mNext + 1;
            if (mNext == NREG) mBusy = 1'b0;
        end
    end

    function automatic logic [DW-1:0] expRead(input int idx, input bit allowBypass);
        if (!idxWritable(idx)) return '0;
`ifdef REGFILE_BYPASS_EN
        if (allowBypass && !mBusy && we && (int'(wr) == idx)) return wd;
`endif
        return model[idx];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (checkOn) begin
            for (int p = 0; p < NRD; p++) begin
                check($sformatf("readPort%0d", p), 64'(rdData[p*DW +: DW]),
                      64'(expRead(int'(rdIdx[p*AW +: AW]), 1'b1)));
            end
            check("debugOut", 64'(dbgOut), 64'(expRead(int'(dbgSel), 1'b0)));
            check("clearBusy", 64'(busy), 64'(mBusy));
            check("writeDropped", 64'(dropped), 64'(mDrop));
        end
    end

    task automatic atPos();
        @(posedge clock);
        #1;
    endtask

    task automatic atNeg();
        @(negedge clock);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int busyCount;

    initial begin
        #1 rst_n = 1'b0;
        checkOn = 1'b1;
        repeat (3) atPos();
        rst_n = 1'b1;

        // After reset every register reads zero on both ports and debug.
        for (int i = 0; i < NREG; i++) begin
            rdIdx  = {AW'(NREG - 1 - i), AW'(i)};
            dbgSel = AW'(i);
            atNeg();
            check("resetReadA", 64'(rdData[0 +: DW]), 64'h0);
            check("resetDebug", 64'(dbgOut), 64'h0);
            atPos();
        end
        check("resetBusy", 64'(busy), 64'h0);
        check("resetDropped", 64'(dropped), 64'h0);

        // r5 accepts a write, r0 ignores one.
        we = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF;
        atPos();
        wr = 5'd0; wd = 32'h12345678;
        atPos();
        we = 1'b0; rdIdx = {5'd0, 5'd5}; dbgSel = 5'd5;
        atNeg();
        check("r5Read", 64'(rdData[0 +: DW]), 64'hDEADBEEF);
        check("r0Read", 64'(rdData[DW +: DW]), 64'h0);
        check("r5Debug", 64'(dbgOut), 64'hDEADBEEF);

        // Same-cycle write and read of r7.
        atPos();
        we = 1'b1; wr = 5'd7; wd = 32'hA5A5A5A5; rdIdx = {5'd5, 5'd7};
        atNeg();
`ifdef REGFILE_BYPASS_EN
        check("r7SameCycle", 64'(rdData[0 +: DW]), 64'hA5A5A5A5);
`else
        check("r7SameCycle", 64'(rdData[0 +: DW]), 64'h0);
`endif
        atPos();
        we = 1'b0;
        atNeg();
        check("r7NextCycle", 64'(rdData[0 +: DW]), 64'hA5A5A5A5);

        // Fill r1..r31 with their index, then run a sweep.
        for (int i = 1; i < NREG; i++) begin
            atPos();
            we = 1'b1; wr = AW'(i); wd = DW'(i);
        end
        atPos();
        we = 1'b0; clr = 1'b1;
        atPos();
        clr = 1'b0;
        busyCount = 0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) atPos();
            we = (k == 5);
            wr = 5'd20;
            wd = 32'hFFFFFFFF;
            clr = (k == 10);
            atNeg();
            if (busy) busyCount++;
            if (k == 3) begin
                rdIdx = {5'd2, 5'd1}; dbgSel = 5'd3;
                #1;
                check("sweepR1", 64'(rdData[0 +: DW]), 64'h0);
                check("sweepR2", 64'(rdData[DW +: DW]), 64'h0);
                check("sweepR3", 64'(dbgOut), 64'h0);
                rdIdx = {5'd20, 5'd4};
                #1;
                check("sweepR4", 64'(rdData[0 +: DW]), 64'h4);
            end
            if (k == 6) check("droppedPulse", 64'(dropped), 64'h1);
            if (k == 7) check("droppedEnd", 64'(dropped), 64'h0);
        end
        check("busyCycles", 64'(busyCount), 64'd31);
        rdIdx = {5'd31, 5'd20};
        #1;
        check("r20AfterSweep", 64'(rdData[0 +: DW]), 64'h0);
        check("r31AfterSweep", 64'(rdData[DW +: DW]), 64'h0);

        // Asynchronous reset in the middle of a sweep.
        atPos();
        we = 1'b1; wr = 5'd9; wd = 32'h5;
        atPos();
        we = 1'b0; clr = 1'b1;
        atPos();
        clr = 1'b0;
        atPos();
        atPos();
        check("midSweepBusy", 64'(busy), 64'h1);
        #3 rst_n = 1'b0;
        #1;
        check("asyncBusy", 64'(busy), 64'h0);
        check("asyncDropped", 64'(dropped), 64'h0);
        rdIdx = {5'd31, 5'd9}; dbgSel = 5'd9;
        #1;
        check("asyncR9", 64'(rdData[0 +: DW]), 64'h0);
        check("asyncR31", 64'(rdData[DW +: DW]), 64'h0);
        atNeg();
        #2 rst_n = 1'b1;
        atPos();
        we = 1'b1; wr = 5'd9; wd = 32'h1;
        atPos();
        we = 1'b0; rdIdx = {5'd0, 5'd9};
        atNeg();
        check("writeAfterReset", 64'(rdData[0 +: DW]), 64'h1);

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 1500; n++) begin
            atPos();
            we     = ($urandom_range(0, 1) == 1);
            wr     = AW'($urandom_range(0, (1 << AW) - 1));
            wd     = $urandom;
            rdIdx  = NRD*AW'($urandom);
            if ($urandom_range(0, 3) == 0) rdIdx[0 +: AW] = wr;
            dbgSel = AW'($urandom_range(0, (1 << AW) - 1));
            clr    = ($urandom_range(0, 39) == 0);
        end
        atPos();
        we = 1'b0; clr = 1'b0;
        atNeg();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
